// File: rtl/s2p.sv
// s2p: serial-to-parallel receiver, the downstream counterpart of p2s.
//
// Samples serial_in MSB-first for a programmable number of bits (1..15) and
// assembles them left-aligned in a WIDTH-bit word, so a p2s->s2p loopback
// returns the word that was given to p2s.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      one-cycle request to begin a reception; latches len
//   len        number of bits to receive (1..2^LEN_W-1), sampled with start
//   enable     sample qualifier while receiving
//   serial_in  serial data line, MSB first
//   data_out   last completed word; received bits in the upper len bits,
//              all lower bits zero
//   done       one-cycle pulse, high in the cycle after the last capture
//   busy       high while receiving
//   state_dbg  current FSM state (IDLE=0, RECV=1, FIN=2)
//
// Control semantics: start is a single-cycle request with no back-pressure.
// It is honoured in every state (IDLE, RECV as abort/restart, FIN as a
// back-to-back restart); len=0 with start never begins a reception.
// done is a single-cycle pulse with no acknowledge; data_out is valid from
// the cycle done is high until the next completed reception.
module s2p #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] cnt_inc;
  logic [IDX_W-1:0] bit_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      data_q    <= '0;
      cnt       <= '0;
      len_q     <= '0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      data_q    <= data_n;
      cnt       <= cnt_n;
      len_q     <= len_n;
    end
  end

  // The counter never exceeds len_q (<= 2^LEN_W-1 < WIDTH), so bit_idx
  // stays >= 1 and bit 0 of the word is never written.
  assign cnt_inc = cnt + LEN_W'(1);
  assign bit_idx = IDX_W'(WIDTH - 1) - IDX_W'(cnt);

  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    data_n  = data_q;
    cnt_n   = cnt;
    len_n   = len_q;

    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          len_n   = len;
          shift_n = '0;
          cnt_n   = '0;
          state_n = RECV;
        end
      end

      RECV: begin
        // start outranks a sample on the same edge: the partial word is
        // dropped without a done pulse and data_out keeps its old value.
        if (start) begin
          len_n   = len;
          shift_n = '0;
          cnt_n   = '0;
          state_n = (len != '0) ? RECV : IDLE;
        end else if (enable) begin
          shift_n[bit_idx] = serial_in;
          cnt_n            = cnt_inc;
          if (cnt_inc == len_q) begin
            // Publish on the same edge that enters FIN so data_out is
            // already valid while done is high.
            data_n  = shift_n;
            state_n = FIN;
          end
        end
      end

      FIN: begin
        if (start && (len != '0)) begin
          len_n   = len;
          shift_n = '0;
          cnt_n   = '0;
          state_n = RECV;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign done      = (state == FIN);
  assign busy      = (state == RECV);
  assign state_dbg = state;

endmodule

// File: tb/tb_s2p.sv
// Testbench for s2p: table-driven receptions plus hand-written corner
// sequences (len=0, abort, back-to-back, asynchronous reset, p2s loopback).
// Expected words and busy lengths are queued when a reception is started
// and checked whenever the DUT pulses done.
module tb_s2p;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // driver-side signals
  logic       start;
  logic [3:0] len;
  logic       enable;
  logic       serial_in;

  // p2s loopback model
  logic        lb;
  logic        p2s_en;
  logic [15:0] p2s_word;
  int          p2s_idx;
  logic        p2s_line;
  logic        en_d;

  logic s_en, s_ser;
  assign s_en  = lb ? en_d : enable;
  assign s_ser = lb ? p2s_line : serial_in;

  // DUT outputs
  logic [W-1:0] data_out;
  logic         done;
  logic         busy;
  logic [1:0]   state_dbg;

  s2p #(.WIDTH(16), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .enable    (s_en),
    .serial_in (s_ser),
    .data_out  (data_out),
    .done      (done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // p2s: registered output, first bit visible one cycle after p2s_en rises;
  // the s2p enable follows p2s_en by one cycle.
  always @(posedge clk) begin
    if (p2s_en) begin
      p2s_line <= p2s_word[15 - p2s_idx];
      p2s_idx  <= p2s_idx + 1;
    end else begin
      p2s_idx  <= 0;
    end
    en_d <= p2s_en;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           exp_busy_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           done_cnt = 0;
  int           busy_cnt = 0;
  logic [W-1:0] last_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  // monitor: samples on the falling edge
  initial begin
    logic [W-1:0] e;
    int           b;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        else if (!done) busy_cnt = 0;
        if (done) begin
          done_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_done at %0t: got done=1, expected no done", $time);
          end else begin
            e = exp_q.pop_front();
            b = exp_busy_q.pop_front();
            chk("data_out_at_done", 32'(data_out), 32'(e));
            chk("busy_at_done", 32'(busy), 32'd0);
            if (b >= 0) chk("busy_cycles", busy_cnt, b);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // driver tasks: called right after a falling edge, return on a falling edge
  task automatic wait_drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout at %0t: got %0d pending words, expected 0", $time, exp_q.size());
      exp_q.delete();
      exp_busy_q.delete();
    end
  endtask

  task automatic recv(input logic [3:0] l, input logic [15:0] w, input int pause_at,
                      input int pause_len, input logic [15:0] expv, input int exp_busy,
                      input bit drain);
    start  = 1'b1;
    len    = l;
    enable = 1'b0;
    exp_q.push_back(expv);
    exp_busy_q.push_back(exp_busy);
    last_exp = expv;
    @(negedge clk);
    start = 1'b0;
    len   = 4'($urandom_range(0, 15));  // must be ignored outside start
    for (int i = 0; i < int'(l); i++) begin
      if (i == pause_at) begin
        repeat (pause_len) begin
          enable    = 1'b0;
          serial_in = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      enable    = 1'b1;
      serial_in = w[15 - i];
      @(negedge clk);
    end
    enable = 1'b0;
    if (drain) wait_drain();
  endtask

  typedef struct {
    logic [3:0]  len;
    logic [15:0] word;
    int          pause_at;
    int          pause_len;
    logic [15:0] exp_data;
    int          exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0]  rl;
    logic [15:0] rw, rmask;
    int          pa, pl, d0;

    vecs[0] = '{4'd8,  16'hB200, 99, 0, 16'hB200, 8};
    vecs[1] = '{4'd4,  16'hD000, 2,  3, 16'hD000, 7};
    vecs[2] = '{4'd1,  16'h8000, 99, 0, 16'h8000, 1};
    vecs[3] = '{4'd15, 16'hFFFF, 99, 0, 16'hFFFE, 15};
    vecs[4] = '{4'd12, 16'h5A5F, 99, 0, 16'h5A50, 12};
    vecs[5] = '{4'd7,  16'hFFFF, 0,  2, 16'hFE00, 9};
    vecs[6] = '{4'd3,  16'h6000, 1,  1, 16'h6000, 4};

    reset = 1'b1; start = 1'b0; len = '0; enable = 1'b0; serial_in = 1'b0;
    lb = 1'b0; p2s_en = 1'b0; p2s_word = '0;
    repeat (2) @(negedge clk);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // table-driven receptions
    for (int i = 0; i < 7; i++)
      recv(vecs[i].len, vecs[i].word, vecs[i].pause_at, vecs[i].pause_len,
           vecs[i].exp_data, vecs[i].exp_busy, 1'b1);

    // random receptions against a masking model
    for (int i = 0; i < 4; i++) begin
      rl    = 4'($urandom_range(1, 15));
      rw    = 16'($urandom_range(0, 65535));
      rmask = 16'hFFFF << (16 - int'(rl));
      pa    = $urandom_range(0, int'(rl) - 1);
      pl    = $urandom_range(0, 2);
      recv(rl, rw, pa, pl, rw & rmask, int'(rl) + pl, 1'b1);
    end

    // start with len=0 in IDLE is ignored
    recv(4'd8, 16'h3C00, 99, 0, 16'h3C00, 8, 1'b1);
    start = 1'b1; len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_state", 32'(state_dbg), 32'd0);
      chk("len0_data_out", 32'(data_out), 32'(last_exp));
      @(negedge clk);
    end

    // start with len=0 during RECV aborts to IDLE; start beats the sample
    start = 1'b1; len = 4'd8;
    @(negedge clk);
    start = 1'b0; enable = 1'b1; serial_in = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1; len = 4'd0;
    @(negedge clk);
    start = 1'b0; enable = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_data_out", 32'(data_out), 32'(last_exp));
    repeat (2) @(negedge clk);

    // abort and restart: only the restarted word completes
    d0 = done_cnt;
    start = 1'b1; len = 4'd8;
    @(negedge clk);
    start = 1'b0; enable = 1'b1; serial_in = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    chk("abort_data_out_held", 32'(data_out), 32'(last_exp));
    recv(4'd2, 16'h4000, 99, 0, 16'h4000, -1, 1'b1);
    @(negedge clk);
    chk("abort_done_count", done_cnt - d0, 1);

    // back-to-back: start during FIN is honoured, done still pulses
    d0 = done_cnt;
    recv(4'd2, 16'hC000, 99, 0, 16'hC000, 2, 1'b0);
    recv(4'd3, 16'hA000, 99, 0, 16'hA000, 3, 1'b1);
    chk("b2b_done_count", done_cnt - d0, 2);

    // asynchronous reset mid-reception
    start = 1'b1; len = 4'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enable = 1'b1;
      serial_in = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("async_reset_data_out", 32'(data_out), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_done", 32'(done), 32'd0);
    chk("async_reset_state", 32'(state_dbg), 32'd0);
    #1 reset = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    recv(4'd8, 16'hA500, 99, 0, 16'hA500, 8, 1'b1);

    // p2s loopback, s2p enable one cycle behind p2s enable
    d0 = done_cnt;
    lb = 1'b1;
    p2s_word = 16'hC3A0;
    start = 1'b1; len = 4'd11;
    exp_q.push_back(16'hC3A0);
    exp_busy_q.push_back(12);
    @(negedge clk);
    start = 1'b0;
    p2s_en = 1'b1;
    repeat (11) @(negedge clk);
    p2s_en = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);
    chk("loopback_done_count", done_cnt - d0, 1);
    chk("loopback_data_out", 32'(data_out), 32'h0000C3A0);
    lb = 1'b0;

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/s2p.md
Name: s2p

Overview:
- Serial-to-parallel receiver; the downstream counterpart of the team's p2s transmitter.
- Samples a single-bit serial line MSB-first for a programmable number of bits (1..15).
- Assembles the bits into a 16-bit word left-aligned in the upper bits, matching p2s data_in alignment, so a p2s->s2p loopback returns the same word.
- Pulses done when the word is complete; the word is then consumed by the protocol controller.

Parameters:
- WIDTH, 16, width of the parallel word (bit WIDTH-1 is the first bit received).
- LEN_W, 4, width of the len input; legal len range is 1..(2^LEN_W - 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a new reception; latches len.
- len  input  LEN_W  number of bits to receive (1..15); sampled only when start=1.
- enable  input  1  sample qualifier; a bit is captured only on cycles with enable=1 while receiving.
- serial_in  input  1  serial data line, MSB first.
- data_out  output  WIDTH  assembled word; bits [15:16-len] hold the received bits; all lower bits are 0.
- done  output  1  one-cycle pulse when the last bit has been captured.
- busy  output  1  high while in RECV.

Behaviour:
- Reset (asynchronous, any time, including mid-reception):
  - state=IDLE, data_out=0, done=0, busy=0, internal bit counter=0, latched len=0.
  - The effect is immediate, without waiting for clk.
- States: IDLE, RECV, FIN.
- IDLE:
  - done=0.
  - start=1 with len!=0 -> latch len, clear shift register to 0, counter=0, go to RECV.
  - start=1 with len=0 -> ignored; stay IDLE with no done pulse.
  - data_out keeps its last completed word.
- RECV:
  - busy=1.
  - Each edge with enable=1: shift_reg[WIDTH-1-counter] <= serial_in; counter <= counter+1.
  - enable=0: hold (pause); no bit is captured and the counter is unchanged.
  - When the bit captured on this edge brings the counter to latched len -> go to FIN.
  - start=1 in RECV aborts and restarts: re-latch len (len=0 -> go IDLE), clear shift register and counter. Start has priority over the sample on that edge. No done is produced for the aborted word. data_out is not updated.
- FIN (exactly one cycle):
  - done=1, busy=0.
  - data_out = shift register; it becomes valid in the same cycle done is high.
  - Next edge -> IDLE, done=0.
  - start=1 while in FIN is honoured: go to RECV with a fresh latch. The done pulse in FIN is still produced.
- Latency:
  - First bit captured on the first enable=1 edge after the start edge.
  - done is high for the cycle after the edge that captured bit len.
- Width rules:
  - counter is LEN_W bits; it never exceeds latched len (max 15), so no wrap.
  - Bit WIDTH-1-counter is always >= 1, so data_out[0] is always 0.
- Changes to len outside the start cycle have no effect.
- serial_in is sampled unconditionally during RECV+enable. The bench must drive known 0/1 values; a released (z) line is not a legal sample.
- Pairing with p2s:
  - p2s registers its output, so its first bit is visible one cycle after its enable rises.
  - The controller asserts s2p enable one cycle after p2s enable.

Test Plan:
- Basic 8-bit: start with len=8, then 8 cycles of enable=1 with serial_in=1,0,1,1,0,0,1,0 -> done pulses 1 cycle after the 8th sample; data_out=16'hB200; busy high for exactly 8 cycles.
- Pause: len=4, bits 1,1,0,1 with enable low for 3 cycles between bits 2 and 3 -> no capture during the pause; done after the 4th enabled sample; data_out=16'hD000.
- Boundaries:
  - len=1, serial_in=1 -> data_out=16'h8000.
  - len=15, all ones -> data_out=16'hFFFE.
  - start with len=0 -> stays IDLE, busy=0, no done, data_out unchanged.
- Abort/restart: len=8, 3 bits received, then start with len=2 and bits 0,1 -> only one done, data_out=16'h4000.
- Reset mid-operation: assert reset asynchronously (between edges) after 5 of 8 bits -> data_out=0, busy=0, done=0 immediately. A subsequent full len=8 reception of 16'hA5 upper byte gives data_out=16'hA500.
- Loopback: p2s data_in=16'hC3A0, len=11, driving s2p with a one-cycle-delayed enable -> s2p data_out=16'hC3A0; done asserted once.
